// File: rtl/intr_cpu_responder.sv
// CPU-side interrupt responder: acknowledges a controller request, reads the
// source ID off the shared bus, runs the service routine and returns a done code.
`timescale 1ns/1ps

module intr_cpu_responder #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       intr_req,
   output logic       intr_ack_n,
   inout  wire  [7:0] intr_bus,
   output logic       cpu_bus_oe,
   output logic       isr_start,
   output logic [2:0] isr_id,
   input  logic       isr_done,
   output logic       busy,
   output logic       proto_err,
   output logic [7:0] serviced_cnt
);

   localparam int unsigned CNT_W       = $clog2(TIMEOUT + 1);
   localparam logic [4:0]  ID_PREFIX   = 5'b01011;
   localparam logic [4:0]  DONE_PREFIX = 5'b10100;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACK_REQ,
      S_WAIT_ID,
      S_ACK_ID,
      S_ISR,
      S_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [2:0]         isr_id_q, isr_id_d;
   logic               proto_err_q, proto_err_d;
   logic [7:0]         serviced_cnt_q, serviced_cnt_d;
   logic               ack_n_q, ack_n_d;
   logic               bus_oe_q, bus_oe_d;
   logic [7:0]         bus_out_q, bus_out_d;
   logic               isr_start_q, isr_start_d;
   logic               busy_q, busy_d;

   // Next state plus output values derived from the state being entered
   always_comb begin
      state_d        = state_q;
      wait_cnt_d     = wait_cnt_q;
      isr_id_d       = isr_id_q;
      proto_err_d    = proto_err_q;
      serviced_cnt_d = serviced_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (intr_req && enable) state_d = S_ACK_REQ;
         end
         S_ACK_REQ: begin
            wait_cnt_d = '0;
            state_d    = S_WAIT_ID;
         end
         S_WAIT_ID: begin
            if (intr_bus[7:3] == ID_PREFIX) begin
               isr_id_d = intr_bus[2:0];
               state_d  = S_ACK_ID;
            end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
               proto_err_d = 1'b1;
               state_d     = S_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         S_ACK_ID: begin
            state_d = S_ISR;
         end
         S_ISR: begin
            if (isr_done) state_d = S_DONE;
         end
         S_DONE: begin
            serviced_cnt_d = serviced_cnt_q + 8'd1;
            state_d        = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      ack_n_d     = !((state_d == S_ACK_REQ) || (state_d == S_ACK_ID) || (state_d == S_DONE));
      bus_oe_d    = (state_d == S_DONE);
      bus_out_d   = {DONE_PREFIX, isr_id_d};
      isr_start_d = (state_q == S_ACK_ID) && (state_d == S_ISR);
      busy_d      = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         wait_cnt_q     <= '0;
         isr_id_q       <= '0;
         proto_err_q    <= 1'b0;
         serviced_cnt_q <= '0;
         ack_n_q        <= 1'b1;
         bus_oe_q       <= 1'b0;
         bus_out_q      <= '0;
         isr_start_q    <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         wait_cnt_q     <= wait_cnt_d;
         isr_id_q       <= isr_id_d;
         proto_err_q    <= proto_err_d;
         serviced_cnt_q <= serviced_cnt_d;
         ack_n_q        <= ack_n_d;
         bus_oe_q       <= bus_oe_d;
         bus_out_q      <= bus_out_d;
         isr_start_q    <= isr_start_d;
         busy_q         <= busy_d;
      end
   end

   assign intr_bus     = bus_oe_q ? bus_out_q : 8'bzzzzzzzz;
   assign intr_ack_n   = ack_n_q;
   assign cpu_bus_oe   = bus_oe_q;
   assign isr_start    = isr_start_q;
   assign isr_id       = isr_id_q;
   assign busy         = busy_q;
   assign proto_err    = proto_err_q;
   assign serviced_cnt = serviced_cnt_q;

endmodule

// File: tb/tb_intr_cpu_responder.sv
// Randomized bench for intr_cpu_responder: a controller model issues
// transactions, a monitor checks every observed strobe against a queue of expected events.
`timescale 1ns/1ps

module tb_intr_cpu_responder;

   localparam int unsigned TIMEOUT = 16;
   localparam int          EV_ACK   = 'h100;
   localparam int          EV_START = 'h200;
   localparam int          EV_DONE  = 'h300;
   localparam int          EV_BAD   = 'h400;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       intr_req = 1'b0;
   logic       isr_done = 1'b0;
   logic       ctl_oe = 1'b0;
   logic [7:0] ctl_data = 8'h00;
   wire  [7:0] intr_bus;
   logic       intr_ack_n, cpu_bus_oe, isr_start, busy, proto_err;
   logic [2:0] isr_id;
   logic [7:0] serviced_cnt;

   int n_chk = 0;
   int n_fail = 0;
   int exp_q[$];
   int model_cnt = 0;
   bit model_err = 1'b0;

   assign intr_bus = ctl_oe ? ctl_data : 8'bzzzzzzzz;

   intr_cpu_responder #(.TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .intr_req     (intr_req),
      .intr_ack_n   (intr_ack_n),
      .intr_bus     (intr_bus),
      .cpu_bus_oe   (cpu_bus_oe),
      .isr_start    (isr_start),
      .isr_id       (isr_id),
      .isr_done     (isr_done),
      .busy         (busy),
      .proto_err    (proto_err),
      .serviced_cnt (serviced_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Observed event stream: ack strobe, ISR launch with ID, done code on the bus
   always @(negedge clk) begin
      int ev;
      ev = -1;
      if (!reset) begin
         if (cpu_bus_oe) begin
            ev = (intr_ack_n ? EV_BAD : EV_DONE) | int'(intr_bus);
            chk("bus_contention", int'(ctl_oe), 0);
         end else if (isr_start) begin
            ev = EV_START | int'(isr_id);
         end else if (!intr_ack_n) begin
            ev = EV_ACK;
         end
         if (ev >= 0) begin
            if (exp_q.size() == 0) chk("unexpected_event", ev, 0);
            else chk("event", ev, exp_q.pop_front());
         end
      end
   end

   // which: 0 = ack low, 1 = isr_start, 2 = cpu_bus_oe
   task automatic wait_neg(input string name, input int which, output int lat);
      bit ok;
      ok  = 1'b0;
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         lat++;
         case (which)
            0:       ok = !intr_ack_n;
            1:       ok = isr_start;
            default: ok = cpu_bus_oe;
         endcase
         if (ok) break;
      end
      if (!ok) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: event not seen within 40 cycles", name);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_ack_n"}, int'(intr_ack_n), 1);
      chk({tag, "_oe"}, int'(cpu_bus_oe), 0);
      chk({tag, "_isr_start"}, int'(isr_start), 0);
      chk({tag, "_isr_id"}, int'(isr_id), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_proto_err"}, int'(proto_err), 0);
      chk({tag, "_cnt"}, int'(serviced_cnt), 0);
   endtask

   // mode 0: full service, 1: bus left floating (timeout), 2: stop once ISR starts
   task automatic run_txn(input logic [2:0] id, input int mode);
      int         lat;
      logic [7:0] g;
      exp_q.push_back(EV_ACK);
      if (mode != 1) begin
         exp_q.push_back(EV_ACK);
         exp_q.push_back(EV_START | int'(id));
         if (mode == 0) exp_q.push_back(EV_DONE | (160 + int'(id)));
      end
      @(posedge clk); #1;
      reset    = 1'b0;
      enable   = 1'b1;
      intr_req = 1'b1;
      wait_neg("ack_req", 0, lat);
      chk("accept_latency", lat, 2);
      @(posedge clk); #1;
      intr_req = 1'b0;
      enable   = 1'($urandom_range(0, 1));
      if (mode == 1) begin
         repeat (TIMEOUT) @(negedge clk);
         chk("wait_busy", int'(busy), 1);
         chk("wait_no_err_yet", int'(proto_err), int'(model_err));
         @(negedge clk);
         model_err = 1'b1;
         chk("timeout_err", int'(proto_err), 1);
         chk("timeout_idle", int'(busy), 0);
      end else begin
         repeat ($urandom_range(0, 3)) begin
            g = 8'($urandom);
            if (g[7:3] == 5'b01011) g[7] = ~g[7];
            ctl_data = g;
            ctl_oe   = 1'b1;
            @(posedge clk); #1;
         end
         ctl_data = {5'b01011, id};
         ctl_oe   = 1'b1;
         wait_neg("ack_id", 0, lat);
         @(posedge clk); #1;
         ctl_oe = 1'b0;
         wait_neg("isr_start", 1, lat);
         if (mode == 0) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            @(posedge clk); #1;
            isr_done = 1'b1;
            @(posedge clk); #1;
            isr_done = 1'b0;
            wait_neg("done_code", 2, lat);
            model_cnt++;
            @(negedge clk);
            chk("serviced_cnt", int'(serviced_cnt), model_cnt % 256);
            chk("idle_after_done", int'(busy), 0);
            chk("proto_err_hold", int'(proto_err), int'(model_err));
         end
      end
   endtask

   initial begin
      #(200000 * 10);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("init");

      // Source 5, then 0 and 7 back to back
      run_txn(3'd5, 0);
      run_txn(3'd0, 0);
      run_txn(3'd7, 0);
      chk("cnt_after_three", int'(serviced_cnt), 3);

      // Timeout, then sticky error while later requests still complete
      run_txn(3'($urandom), 1);
      run_txn(3'd2, 0);
      run_txn(3'($urandom), 0);

      // Request held while disabled is not acknowledged
      @(posedge clk); #1;
      enable   = 1'b0;
      intr_req = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk("ack_while_disabled", int'(intr_ack_n), 1);
      end
      run_txn(3'd4, 0);

      // Reset while servicing ID 3, then a normal transaction straight out of reset
      run_txn(3'd3, 2);
      @(posedge clk); #2;
      reset = 1'b1;
      @(negedge clk);
      check_reset_vals("mid_isr");
      chk("no_pending_done", exp_q.size(), 0);
      exp_q.delete();
      model_cnt = 0;
      model_err = 1'b0;
      repeat (3) @(posedge clk);
      run_txn(3'd6, 0);
      chk("cnt_after_reset", int'(serviced_cnt), 1);

      // Counter wrap after 256 completed services from reset
      @(posedge clk); #1;
      reset = 1'b1;
      exp_q.delete();
      model_cnt = 0;
      model_err = 1'b0;
      repeat (2) @(posedge clk);
      for (int i = 0; i < 256; i++) run_txn(3'($urandom), 0);
      chk("cnt_wrapped", int'(serviced_cnt), 0);

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/intr_cpu_responder.md
INTR_CPU_RESPONDER -- requirements
Module: intr_cpu_responder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum cycles spent in S_WAIT_ID before abort.
REQ-002 SHALL have port clk, input, 1: clock, all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port enable, input, 1: when low, new interrupt requests are not accepted.
REQ-005 SHALL have port intr_req, input, 1: interrupt request from the interrupt controller, synchronous to clk.
REQ-006 SHALL have port intr_ack_n, output, 1: active-low acknowledge strobe to the controller, idle high.
REQ-007 SHALL have port intr_bus, inout, 8: shared bidirectional interrupt bus.
REQ-008 SHALL have port cpu_bus_oe, output, 1: high only while this block drives intr_bus.
REQ-009 SHALL have port isr_start, output, 1: one-cycle pulse launching the service routine.
REQ-010 SHALL have port isr_id, output, 3: source ID being serviced.
REQ-011 SHALL have port isr_done, input, 1: service routine finished, sampled only in S_ISR.
REQ-012 SHALL have port busy, output, 1: high in every state except S_IDLE.
REQ-013 SHALL have port proto_err, output, 1: sticky protocol-timeout flag.
REQ-014 SHALL have port serviced_cnt, output, 8: count of completed services.

Function
REQ-015 SHALL implement states S_IDLE, S_ACK_REQ, S_WAIT_ID, S_ACK_ID, S_ISR and S_DONE, with all outputs registered.
REQ-016 SHALL, in S_IDLE with intr_req=1 and enable=1 sampled, go to S_ACK_REQ; otherwise it SHALL stay in S_IDLE.
REQ-017 SHALL drive intr_ack_n=0 for exactly the one cycle spent in S_ACK_REQ, then go to S_WAIT_ID.
REQ-018 SHALL, in S_WAIT_ID, sample intr_bus each cycle; when intr_bus[7:3]=5'b01011, it SHALL capture intr_bus[2:0] into isr_id and go to S_ACK_ID.
REQ-019 SHALL keep a wait counter, cleared on entry to S_WAIT_ID; if it reaches TIMEOUT without a valid code, proto_err SHALL be set to 1 and the block SHALL return to S_IDLE with the bus undriven.
REQ-020 SHALL drive intr_ack_n=0 for exactly the one cycle spent in S_ACK_ID, then go to S_ISR.
REQ-021 SHALL pulse isr_start=1 on the first S_ISR cycle only, then wait in S_ISR until isr_done=1 is sampled, then go to S_DONE.
REQ-022 SHALL, in S_DONE, for exactly one cycle, drive intr_bus={5'b10100, isr_id}, cpu_bus_oe=1 and intr_ack_n=0 together, then return to S_IDLE.
REQ-023 SHALL increment serviced_cnt on each S_DONE exit, wrapping 255 -> 0.
REQ-024 SHALL tristate intr_bus (8'bzzzzzzzz) in every state except S_DONE.
REQ-025 SHALL keep at least one S_ISR cycle between S_ACK_ID and S_DONE, so the controller's bus release never overlaps this block's drive.
REQ-026 SHALL ignore intr_req in all states except S_IDLE, and SHALL ignore intr_bus content outside S_WAIT_ID.
REQ-027 SHALL NOT abort an in-progress transaction when enable falls.
REQ-028 SHALL hold proto_err at 1 until reset, while still accepting later requests.

Reset
REQ-029 SHALL, on reset assertion at any time including mid-transaction, force S_IDLE, intr_ack_n=1, cpu_bus_oe=0, intr_bus=z, isr_start=0, isr_id=0, proto_err=0, serviced_cnt=0 and busy=0.
REQ-030 SHALL make the first request acceptance the first rising edge after reset deasserts with intr_req=1.

Verification
REQ-031 Normal path: controller model raises intr_req for source 5 -> one-cycle intr_ack_n low; on bus 8'h5D, one more one-cycle ack and isr_id=5; after isr_done, bus 8'hA5 with ack low for 1 cycle; serviced_cnt=1.
REQ-032 Timeout: intr_req pulse with bus left z for 16 cycles -> proto_err=1, state S_IDLE, no isr_start, cpu_bus_oe never 1.
REQ-033 Back-to-back: sources 0 then 7 serviced consecutively -> done codes 8'hA0 then 8'hA7, serviced_cnt=2, and the bus is never driven by both sides in the same cycle.
REQ-034 Reset during S_ISR with ID 3 -> all outputs at reset values on the next sample and no done code issued; a later request completes normally.
REQ-035 enable=0 with intr_req=1 for 10 cycles -> intr_ack_n stays 1 throughout; raising enable -> ack issued the next cycle.
REQ-036 Wrap: 256 completed services -> serviced_cnt returns to 0.
